// File: rtl/sector_cache_param.sv
// Parametrised N-way set-associative sector cache model with hit/miss counters.
// Define LRU_REPLACE_EN for true-LRU victims; otherwise a per-set round-robin pointer.
module sector_cache_param #(
    parameter int ADDR_W       = 31,
    parameter int CNT_W        = 31,
    parameter int BLOCK_BYTES  = 4,
    parameter int SUBBLOCKS    = 4,
    parameter int SETS         = 64,
    parameter int WAYS         = 2,
    parameter int MISS_PENALTY = 4
) (
    input  logic              clk_41,
    input  logic              rst_41,
    input  logic              req_valid_41,
    output logic              req_ready_41,
    input  logic [ADDR_W-1:0] adder_41,
    input  logic              flush_41,
    output logic              resp_valid_41,
    output logic              resp_hit_41,
    output logic [CNT_W-1:0]  hits_41,
    output logic [CNT_W-1:0]  misses_41,
    output logic [CNT_W-1:0]  sector_misses_41
);
    localparam int OFF_W = $clog2(BLOCK_BYTES);
    localparam int SB_W  = $clog2(SUBBLOCKS);
    localparam int SET_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - OFF_W - SB_W - SET_W;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int PEN_W = (MISS_PENALTY > 0) ? $clog2(MISS_PENALTY + 1) : 1;
    localparam logic [PEN_W-1:0] PEN_LOAD =
        PEN_W'((MISS_PENALTY > 0) ? MISS_PENALTY - 1 : 0);
    localparam logic [WAY_W-1:0] LAST_WAY = WAY_W'(WAYS - 1);

    typedef enum logic {IDLE, FILL} state_t;

    state_t               state_q;
    logic [PEN_W-1:0]     pen_q;
    logic                 resp_valid_q;
    logic                 resp_hit_q;
    logic [CNT_W-1:0]     hits_q;
    logic [CNT_W-1:0]     misses_q;
    logic [CNT_W-1:0]     sect_q;
    logic [TAG_W-1:0]     tag_q [SETS][WAYS];
    logic [SUBBLOCKS-1:0] vld_q [SETS][WAYS];
`ifdef LRU_REPLACE_EN
    logic [WAY_W-1:0]     age_q [SETS][WAYS];
`else
    logic [WAY_W-1:0]     rr_q [SETS];
`endif

    logic [SB_W-1:0]  sb_idx;
    logic [SET_W-1:0] set_idx;
    logic [TAG_W-1:0] tag;
    logic             unused_off;

    assign sb_idx     = adder_41[OFF_W +: SB_W];
    assign set_idx    = adder_41[OFF_W+SB_W +: SET_W];
    assign tag        = adder_41[ADDR_W-1 -: TAG_W];
    assign unused_off = ^adder_41[OFF_W-1:0];

    logic             match;
    logic             hit;
    logic             empty;
    logic [WAY_W-1:0] match_way;
    logic [WAY_W-1:0] empty_way;
    logic [WAY_W-1:0] pol_way;
    logic [WAY_W-1:0] victim;

    // A way holding no valid sub-block never counts as a tag match.
    always_comb begin
        match     = 1'b0;
        empty     = 1'b0;
        match_way = '0;
        empty_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (vld_q[set_idx][w] == '0) begin
                empty     = 1'b1;
                empty_way = WAY_W'(w);
            end else if (tag_q[set_idx][w] == tag) begin
                match     = 1'b1;
                match_way = WAY_W'(w);
            end
        end
    end

    assign hit = match & vld_q[set_idx][match_way][sb_idx];

`ifdef LRU_REPLACE_EN
    logic [WAY_W-1:0] oldest_age;
    logic [WAY_W-1:0] acc_way;

    always_comb begin
        pol_way    = '0;
        oldest_age = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (age_q[set_idx][w] > oldest_age) begin
                oldest_age = age_q[set_idx][w];
                pol_way    = WAY_W'(w);
            end
        end
    end

    assign acc_way = match ? match_way : victim;
`else
    assign pol_way = rr_q[set_idx];
`endif

    assign victim = empty ? empty_way : pol_way;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk_41) begin
        if (rst_41) begin
            state_q      <= IDLE;
            pen_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_hit_q   <= 1'b0;
            hits_q       <= '0;
            misses_q     <= '0;
            sect_q       <= '0;
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    vld_q[s][w] <= '0;
`ifdef LRU_REPLACE_EN
                    age_q[s][w] <= '0;
`endif
                end
`ifndef LRU_REPLACE_EN
                rr_q[s] <= '0;
`endif
            end
        end else begin
            resp_valid_q <= 1'b0;
            resp_hit_q   <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (flush_41) begin
                        for (int s = 0; s < SETS; s++) begin
                            for (int w = 0; w < WAYS; w++) begin
                                vld_q[s][w] <= '0;
                            end
                        end
                    end else if (req_valid_41) begin
                        if (hit) begin
                            hits_q       <= sat_inc(hits_q);
                            resp_valid_q <= 1'b1;
                            resp_hit_q   <= 1'b1;
                        end else begin
                            misses_q <= sat_inc(misses_q);
                            if (match) begin
                                vld_q[set_idx][match_way][sb_idx] <= 1'b1;
                            end else begin
                                sect_q <= sat_inc(sect_q);
                                tag_q[set_idx][victim] <= tag;
                                vld_q[set_idx][victim] <=
                                    SUBBLOCKS'(1) << sb_idx;
`ifndef LRU_REPLACE_EN
                                if (!empty) begin
                                    rr_q[set_idx] <=
                                        (rr_q[set_idx] == LAST_WAY) ?
                                        '0 : rr_q[set_idx] + 1'b1;
                                end
`endif
                            end
                            if (MISS_PENALTY == 0) begin
                                resp_valid_q <= 1'b1;
                            end else begin
                                state_q <= FILL;
                                pen_q   <= PEN_LOAD;
                            end
                        end
`ifdef LRU_REPLACE_EN
                        // Ages form a recency rank: 0 = most recent.
                        for (int w = 0; w < WAYS; w++) begin
                            if (WAY_W'(w) == acc_way) begin
                                age_q[set_idx][w] <= '0;
                            end else if (age_q[set_idx][w] <=
                                         age_q[set_idx][acc_way] &&
                                         age_q[set_idx][w] != LAST_WAY) begin
                                age_q[set_idx][w] <= age_q[set_idx][w] + 1'b1;
                            end
                        end
`endif
                    end
                end
                FILL: begin
                    if (pen_q == '0) begin
                        resp_valid_q <= 1'b1;
                        state_q      <= IDLE;
                    end else begin
                        pen_q <= pen_q - 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready_41     = (state_q == IDLE) & ~flush_41 & ~rst_41;
    assign resp_valid_41    = resp_valid_q;
    assign resp_hit_41      = resp_hit_q;
    assign hits_41          = hits_q;
    assign misses_41        = misses_q;
    assign sector_misses_41 = sect_q;

endmodule

// File: tb/tb_sector_cache_param.sv
// Bench for sector_cache_param: vector table, corner sequences and a random
// trace checked against a timestamp/array reference model.
module tb_sector_cache_param;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [30:0] adder = '0;
    logic        flush = 1'b0;
    logic        resp_valid;
    logic        resp_hit;
    logic [30:0] hits;
    logic [30:0] misses;
    logic [30:0] sects;
    logic        unused_rdy4;
    logic        unused_rv4;
    logic        unused_rh4;
    logic [3:0]  hits4;
    logic [3:0]  misses4;
    logic [3:0]  sects4;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sector_cache_param dut (
        .clk_41(clk), .rst_41(rst),
        .req_valid_41(req_valid), .req_ready_41(req_ready),
        .adder_41(adder), .flush_41(flush),
        .resp_valid_41(resp_valid), .resp_hit_41(resp_hit),
        .hits_41(hits), .misses_41(misses),
        .sector_misses_41(sects)
    );

    sector_cache_param #(.CNT_W(4)) dut4 (
        .clk_41(clk), .rst_41(rst),
        .req_valid_41(req_valid), .req_ready_41(unused_rdy4),
        .adder_41(adder), .flush_41(flush),
        .resp_valid_41(unused_rv4), .resp_hit_41(unused_rh4),
        .hits_41(hits4), .misses_41(misses4),
        .sector_misses_41(sects4)
    );

    // Reference model: per-set tag/valid arrays, RR pointer, touch timestamps.
    int          m_tag [64][2];
    bit [3:0]    m_vld [64][2];
    int          m_rr  [64];
    longint      m_used [64][2];
    longint      m_time;
    longint      m_hits;
    longint      m_misses;
    longint      m_sects;

    function automatic void m_flush();
        for (int s = 0; s < 64; s++)
            for (int w = 0; w < 2; w++) m_vld[s][w] = '0;
    endfunction

    function automatic void m_reset();
        m_flush();
        for (int s = 0; s < 64; s++) begin
            m_rr[s] = 0;
            m_used[s][0] = 0;
            m_used[s][1] = 0;
        end
        m_time = 0;
        m_hits = 0;
        m_misses = 0;
        m_sects = 0;
    endfunction

    function automatic void m_access(input logic [30:0] a, output bit h);
        int s;
        int sb;
        int t;
        int w;
        int v;
        s = int'(a[9:4]);
        sb = int'(a[3:2]);
        t = int'(a[30:10]);
        w = -1;
        v = -1;
        m_time++;
        for (int i = 0; i < 2; i++)
            if (m_vld[s][i] != 0 && m_tag[s][i] == t) w = i;
        if (w >= 0) begin
            h = m_vld[s][w][sb];
            m_vld[s][w][sb] = 1'b1;
            if (h) m_hits++;
            else m_misses++;
            m_used[s][w] = m_time;
        end else begin
            h = 1'b0;
            m_misses++;
            m_sects++;
            for (int i = 1; i >= 0; i--)
                if (m_vld[s][i] == 0) v = i;
            if (v < 0) begin
`ifdef LRU_REPLACE_EN
                v = (m_used[s][1] < m_used[s][0]) ? 1 : 0;
`else
                v = m_rr[s];
                m_rr[s] = (m_rr[s] + 1) % 2;
`endif
            end
            m_tag[s][v] = t;
            m_vld[s][v] = 4'b0001 << sb;
            m_used[s][v] = m_time;
        end
    endfunction

    function automatic longint sat(input longint v, input longint mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_cnt();
        chk("hits", hits, sat(m_hits, 32'h7fffffff));
        chk("misses", misses, sat(m_misses, 32'h7fffffff));
        chk("sects", sects, sat(m_sects, 32'h7fffffff));
        chk("hits4", hits4, sat(m_hits, 15));
        chk("misses4", misses4, sat(m_misses, 15));
        chk("sects4", sects4, sat(m_sects, 15));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req_valid = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        chk("rst_ready", req_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        m_reset();
        chk("rst_ready_after", req_ready, 1);
        chk("rst_resp", resp_valid, 0);
        chk("rst_hit", resp_hit, 0);
        chk_cnt();
    endtask

    task automatic issue(input logic [30:0] a, output bit gh, output int gl);
        @(negedge clk);
        adder = a;
        req_valid = 1'b1;
        chk("issue_ready", req_ready, 1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        gl = 0;
        gh = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (resp_valid) begin
                gl = k;
                gh = resp_hit;
                chk("resp_ready", req_ready, 1);
                break;
            end
            chk("fill_ready", req_ready, 0);
        end
        if (gl == 0) chk("resp_timeout", 0, 1);
    endtask

    task automatic check_req(input logic [30:0] a);
        bit gh;
        bit mh;
        int gl;
        issue(a, gh, gl);
        m_access(a, mh);
        chk("req_hit", gh, mh);
        chk("req_lat", gl, mh ? 1 : 5);
        chk_cnt();
    endtask

    task automatic do_flush(input logic [30:0] a);
        @(negedge clk);
        flush = 1'b1;
        req_valid = 1'b1;
        adder = a;
        #1 chk("flush_ready", req_ready, 0);
        @(negedge clk);
        flush = 1'b0;
        req_valid = 1'b0;
        chk("flush_noresp", resp_valid, 0);
        m_flush();
        chk_cnt();
    endtask

    task automatic b2b(input logic [30:0] a, input int n);
        bit h;
        for (int i = 0; i <= n; i++) begin
            @(negedge clk);
            if (i > 0) begin
                chk("b2b_valid", resp_valid, 1);
                chk("b2b_hit", resp_hit, 1);
            end
            if (i < n) begin
                adder = a;
                req_valid = 1'b1;
                chk("b2b_ready", req_ready, 1);
                m_access(a, h);
            end else begin
                req_valid = 1'b0;
            end
        end
        @(negedge clk);
        chk("b2b_idle", resp_valid, 0);
    endtask

    typedef struct {
        logic [30:0] addr;
        bit          hit;
        int          lat;
        int          h;
        int          m;
        int          s;
    } vec_t;

    vec_t tbl [8];

    initial begin
        bit gh;
        bit mh;
        int gl;
        logic [30:0] ra;

        tbl[0] = '{31'h000, 1'b0, 5, 0, 1, 1};
        tbl[1] = '{31'h000, 1'b1, 1, 1, 1, 1};
        tbl[2] = '{31'h004, 1'b0, 5, 1, 2, 1};
        tbl[3] = '{31'h004, 1'b1, 1, 2, 2, 1};
        tbl[4] = '{31'h400, 1'b0, 5, 2, 3, 2};
        tbl[5] = '{31'h000, 1'b1, 1, 3, 3, 2};
        tbl[6] = '{31'h800, 1'b0, 5, 3, 4, 3};
`ifdef LRU_REPLACE_EN
        tbl[7] = '{31'h400, 1'b0, 5, 3, 5, 4};
`else
        tbl[7] = '{31'h400, 1'b1, 1, 4, 4, 3};
`endif

        do_reset();

        for (int i = 0; i < 8; i++) begin
            issue(tbl[i].addr, gh, gl);
            m_access(tbl[i].addr, mh);
            chk("tbl_hit", gh, tbl[i].hit);
            chk("tbl_lat", gl, tbl[i].lat);
            chk("tbl_hits", hits, tbl[i].h);
            chk("tbl_misses", misses, tbl[i].m);
            chk("tbl_sects", sects, tbl[i].s);
            chk("tbl_hits4", hits4, tbl[i].h);
        end

        do_flush(31'h000);
        issue(31'h000, gh, gl);
        m_access(31'h000, mh);
        chk("postflush_hit", gh, 0);
        chk("postflush_lat", gl, 5);
        chk("postflush_sects", sects, tbl[7].s + 1);
        chk("postflush_hits", hits, tbl[7].h);
        chk_cnt();

        b2b(31'h000, 8);
        chk_cnt();
        b2b(31'h000, 20);
        chk("sat_hits4", hits4, 15);
        chk_cnt();

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                do_flush(31'h000);
            end else begin
                ra = 31'($urandom_range(0, 3)) << 10;
                ra = ra | (31'($urandom_range(0, 1)) << 4);
                ra = ra | (31'($urandom_range(0, 3)) << 2);
                ra = ra | 31'($urandom_range(0, 3));
                check_req(ra);
            end
        end

        do_flush(31'h000);
        @(negedge clk);
        adder = 31'h000;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("midfill_ready", req_ready, 0);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("midfill_noresp", resp_valid, 0);
        end
        rst = 1'b0;
        #1;
        m_reset();
        chk_cnt();
        issue(31'h000, gh, gl);
        m_access(31'h000, mh);
        chk("after_rst_hit", gh, 0);
        chk("after_rst_lat", gl, 5);
        chk("after_rst_sects", sects, 1);
        chk_cnt();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end
endmodule
